// File: rtl/sched_pkg.sv
// Shared sizes, FSM encoding and the round-robin pick helper for onehot_scheduler.
package sched_pkg;

    localparam int N_REQ = 16;
    localparam int IDX_W = 4;
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GRANT   = 2'b01,
        RECOVER = 2'b10
    } state_t;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // First set bit at or above ptr, wrapping 15->0. Scanned from the far end
    // so the candidate closest to ptr is the one left standing.
    function automatic pick_t rr_pick(input logic [N_REQ-1:0] req,
                                      input logic [IDX_W-1:0] ptr);
        pick_t            p;
        logic [IDX_W-1:0] k;
        p = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            k = ptr + IDX_W'(i);
            if (req[k]) begin
                p.found = 1'b1;
                p.idx   = k;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/grant_decode.sv
// Enabled binary-to-one-hot decode used to form the grant vector.
module grant_decode
    import sched_pkg::*;
(
    input  logic             en,
    input  logic [IDX_W-1:0] idx,
    output logic [N_REQ-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) onehot[idx] = 1'b1;
    end

endmodule

// File: rtl/onehot_scheduler.sv
// Round-robin single-owner scheduler: IDLE -> GRANT -> RECOVER, one-hot grant.
// Optional forced release after TIMEOUT_CYCLES when SCHED_TIMEOUT_EN is defined.
// The owner-done input is named release_grant since "release" is a reserved word.
module onehot_scheduler
    import sched_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             release_grant,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid,
    output logic             timeout_pulse
);

    state_t           state, state_nx;
    logic [IDX_W-1:0] ptr, ptr_nx, idx_nx;
    logic             valid_nx;
    logic             grant_end;
    logic             tmo_hit;
    pick_t            pick;

    assign pick = rr_pick(req, ptr);

`ifdef SCHED_TIMEOUT_EN
    logic [CNT_W-1:0] cnt;

    // A real release or a dropped request ends the grant on its own, so the
    // timeout only claims the cycle when nothing else would.
    assign tmo_hit = (state == GRANT) && (cnt == CNT_W'(TIMEOUT_CYCLES - 1))
                     && !release_grant && req[grant_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt           <= '0;
            timeout_pulse <= 1'b0;
        end else begin
            cnt           <= (state == GRANT) ? cnt + 1'b1 : '0;
            timeout_pulse <= tmo_hit;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign tmo_hit            = 1'b0;
    assign timeout_pulse      = 1'b0;
`endif

    assign grant_end = release_grant || !req[grant_idx] || tmo_hit;

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        idx_nx   = grant_idx;
        valid_nx = grant_valid;
        case (state)
            IDLE, RECOVER: begin
                if (pick.found) begin
                    state_nx = GRANT;
                    idx_nx   = pick.idx;
                    valid_nx = 1'b1;
                end else begin
                    state_nx = IDLE;
                    valid_nx = 1'b0;
                end
            end
            GRANT: begin
                if (grant_end) begin
                    state_nx = RECOVER;
                    valid_nx = 1'b0;
                    ptr_nx   = grant_idx + 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
                valid_nx = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= '0;
            grant_idx   <= '0;
            grant_valid <= 1'b0;
        end else begin
            state       <= state_nx;
            ptr         <= ptr_nx;
            grant_idx   <= idx_nx;
            grant_valid <= valid_nx;
        end
    end

    grant_decode u_dec (
        .en     (grant_valid),
        .idx    (grant_idx),
        .onehot (grant)
    );

endmodule

// File: doc/onehot_scheduler.md
ONEHOT_SCHEDULER -- requirements
Module: onehot_scheduler

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 64, maximum cycles one grant is held before forced release; legal range 2..255; used only when SCHED_TIMEOUT_EN is defined.
REQ-002 One clock; reset is asynchronous and active-low.
REQ-003 Port: clk  input  1  rising-edge clock for all state.
REQ-004 Port: rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: req  input  16  request vector, one bit per requester; level-sensitive.
REQ-006 Port: release  input  1  current owner done; sampled only in GRANT.
REQ-007 Port: grant  output  16  registered one-hot grant, all-zero when no owner.
REQ-008 Port: grant_idx  output  4  binary index of the current owner; holds its last value when grant_valid=0.
REQ-009 Port: grant_valid  output  1  high exactly when grant is non-zero.
REQ-010 Port: timeout_pulse  output  1  one-cycle strobe on a forced release.

Function
REQ-011 The FSM SHALL have three states: IDLE, GRANT, RECOVER.
REQ-012 In IDLE with req non-zero, the FSM SHALL select the first set bit searching upward from ptr with wrap 15->0, load grant_idx with it, and enter GRANT; grant_valid rises on the next clock edge (1-cycle latency).
REQ-013 In IDLE with req all-zero, the FSM SHALL stay in IDLE with grant all-zero.
REQ-014 In GRANT, grant and grant_idx SHALL stay constant while release=0 and req[grant_idx]=1.
REQ-015 In GRANT, release=1 or req[grant_idx]=0 SHALL end the grant: next state RECOVER, grant all-zero, ptr=(grant_idx+1) mod 16.
REQ-016 RECOVER SHALL last exactly one cycle with grant all-zero, then apply the IDLE selection rule in the same cycle. A new grant is visible 2 cycles after the release edge.
REQ-017 Requests from other requesters during GRANT SHALL be ignored, and no preemption SHALL occur.
REQ-018 If release and a new request arrive in the same cycle, release SHALL take effect first, and the request is arbitrated in RECOVER.
REQ-019 ptr SHALL update only on grant end, and 4-bit wrap-around from 15 to 0 is required.
REQ-020 grant SHALL equal the one-hot decode of grant_idx gated by grant_valid, and more than one set bit is illegal in every cycle.

Reset
REQ-021 rst_n=0 SHALL immediately force: state IDLE, ptr 0, grant 16'h0000, grant_idx 4'h0, grant_valid 0, timeout_pulse 0, and the timeout counter 0.
REQ-022 A reset asserted during GRANT SHALL drop the grant asynchronously, with no RECOVER cycle and no timeout_pulse.
REQ-023 The first arbitration after reset deassertion SHALL occur on the first rising clk edge with rst_n=1.

Configuration
REQ-024 Macro SCHED_TIMEOUT_EN defined: an 8-bit counter SHALL clear on entry to GRANT and increment each GRANT cycle.
REQ-025 With SCHED_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES-1 with no release, the block SHALL treat that cycle as a release and pulse timeout_pulse high for one cycle coincident with the RECOVER entry.
REQ-026 With SCHED_TIMEOUT_EN defined, a real release in the same cycle as the timeout SHALL win, and no timeout_pulse SHALL be produced.
REQ-027 Macro undefined: the counter SHALL be absent, timeout_pulse SHALL be tied 0, and a grant may be held indefinitely.

Structure
REQ-028 Package sched_pkg SHALL hold N_REQ=16, IDX_W=4, the state encodings (IDLE=2'b00, GRANT=2'b01, RECOVER=2'b10) and CNT_W=8.
REQ-029 Sub-module grant_decode SHALL implement the 4-to-16 one-hot decode with an enable: inputs en and idx[3:0], output onehot[15:0], all-zero when en=0, fully combinational with a default assignment.
REQ-030 Round-robin search SHALL be the only other combinational logic in onehot_scheduler.

Verification
REQ-031 Reset then req=16'h0001 -> after 1 edge grant=16'h0001, grant_idx=0, and grant stays held while release=0.
REQ-032 req=16'hFFFF with release pulsed each grant -> grants in order idx 0,1,...,15,0, with exactly one RECOVER cycle between grants.
REQ-033 Owner idx=15 releases, and req=16'h8001 -> next grant is idx 0 (wrap), not 15.
REQ-034 While granted idx=3, req[3] drops -> grant=0 next cycle, ptr=4, and req[5] is granted 2 cycles later.
REQ-035 SCHED_TIMEOUT_EN defined with TIMEOUT_CYCLES=4, and req=16'h0010 held with no release -> grant drops after 4 GRANT cycles, timeout_pulse is high for 1 cycle, and idx 4 is re-granted after RECOVER.
REQ-036 rst_n pulsed low mid-GRANT -> grant=0 immediately, with no timeout_pulse, and after release of reset with req=16'h0100 the block grants idx 8 on the first edge.
